// File: rtl/shift_add_mac.sv
// shift_add_mac: sequential shift-and-add multiplier with a final addend stage.
// Computes Product = Multiplicand * Multiplier + Addend (unsigned, 5x5 + 5 -> 10 bits)
// with a fixed 6-cycle latency: 5 CALC cycles of shift/add, then 1 ADDC cycle.
//
// Handshake: start/ready is a request/status pair, not a queue. start is sampled
// only on a rising edge while the FSM is IDLE (ready=1); that edge latches the
// operands and drops ready. A start seen in CALC or ADDC is discarded. ready rises
// on the edge that writes Product, and Product then holds until the next completion.
module shift_add_mac (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] Multiplicand,
  input  logic [4:0] Multiplier,
  input  logic [4:0] Addend,
  output logic [9:0] Product,
  output logic       ready,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADDC = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] a_q, a_d;
  logic [4:0] c_q, c_d;
  logic [5:0] hi_q, hi_d;
  logic [4:0] lo_q, lo_d;
  logic [2:0] cnt_q, cnt_d;
  logic [9:0] product_q, product_d;
  logic       ready_q, ready_d;
  logic [5:0] sum;

  // Register all state; reset clears everything and leaves the block ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= 5'd0;
      c_q       <= 5'd0;
      hi_q      <= 6'd0;
      lo_q      <= 5'd0;
      cnt_q     <= 3'd0;
      product_q <= 10'd0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      c_q       <= c_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and datapath control for IDLE -> CALC (x5) -> ADDC -> IDLE.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    c_d       = c_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready_d   = ready_q;
    // Partial-product add; hi_q[5] is always 0 here because the previous shift
    // brought in a zero, so the 6-bit sum keeps the carry without overflow.
    sum       = hi_q + (lo_q[0] ? {1'b0, a_q} : 6'd0);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = Multiplicand;
          c_d     = Addend;
          lo_d    = Multiplier;
          hi_d    = 6'd0;
          cnt_d   = 3'd4;
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Shift {sum, lo} right by one: carry lands in hi, sum LSB enters lo MSB.
        hi_d = {1'b0, sum[5:1]};
        lo_d = {sum[0], lo_q[4:1]};
        if (cnt_q == 3'd0) begin
          state_d = ADDC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ADDC: begin
        product_d = {hi_q[4:0], lo_q} + {5'd0, c_q};
        ready_d   = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Product   = product_q;
  assign ready     = ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_mac.sv
// tb_shift_add_mac: directed, table-driven bench for shift_add_mac.
module tb_shift_add_mac;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] mc;
  logic [4:0] ml;
  logic [4:0] ad;
  logic [9:0] product;
  logic       ready;
  logic [1:0] dbg_state;

  int n_checks;
  int n_errors;
  logic [9:0] last_exp;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] c;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[8];

  shift_add_mac dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Multiplicand (mc),
    .Multiplier   (ml),
    .Addend       (ad),
    .Product      (product),
    .ready        (ready),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full operation with a 1-cycle start pulse; operands scrambled after edge 0.
  task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [9:0] exp, input string name);
    @(negedge clk);
    mc = a; ml = b; ad = c; start = 1'b1;
    @(posedge clk); #1;
    check({name, "_ready_fall"}, {9'd0, ready}, 10'd0);
    @(negedge clk);
    start = 1'b0;
    mc = 5'($urandom_range(0, 31));
    ml = 5'($urandom_range(0, 31));
    ad = 5'($urandom_range(0, 31));
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0 || product !== last_exp) begin
        check({name, "_busy_hold"}, {ready, product[8:0]}, {1'b0, last_exp[8:0]});
      end
    end
    @(posedge clk); #1;
    check({name, "_ready_rise"}, {9'd0, ready}, 10'd1);
    exp_q.push_back(exp);
    check({name, "_product"}, product, exp_q.pop_front());
    last_exp = exp;
  endtask

  initial begin
    int dvd, q, r;
    n_checks = 0;
    n_errors = 0;
    last_exp = 10'd0;
    start = 1'b0; mc = 5'd0; ml = 5'd0; ad = 5'd0;

    dvd = 200; q = dvd / 13; r = dvd % 13;
    vecs[0] = '{5'd13, 5'd7,  5'd5,  10'd96};
    vecs[1] = '{5'd31, 5'd31, 5'd31, 10'd992};
    vecs[2] = '{5'd0,  5'd25, 5'd0,  10'd0};
    vecs[3] = '{5'd17, 5'd0,  5'd9,  10'd9};
    vecs[4] = '{5'd13, 5'(q), 5'(r), 10'd200};
    vecs[5] = '{5'd1,  5'd1,  5'd0,  10'd1};
    vecs[6] = '{5'd31, 5'd1,  5'd0,  10'd31};
    vecs[7] = '{5'd5,  5'd6,  5'd7,  10'd37};

    // Reset state
    rst = 1'b0;
    #12;
    check("reset_ready", {9'd0, ready}, 10'd1);
    check("reset_product", product, 10'd0);
    check("reset_state", {8'd0, dbg_state}, 10'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Start re-pulsed mid-operation and operands changed: 3*4+1 = 13, no second op
    @(negedge clk);
    mc = 5'd3; ml = 5'd4; ad = 5'd1; start = 1'b1;
    @(posedge clk);                               // edge 0
    @(negedge clk); start = 1'b0;
    @(posedge clk);                               // edge 1
    @(negedge clk); mc = 5'd9; ml = 5'd9; ad = 5'd9;
    @(posedge clk);                               // edge 2
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;                           // edge 3
    check("ignore_start_busy", {9'd0, ready}, 10'd0);
    @(negedge clk); start = 1'b0;
    @(posedge clk);                               // edge 4
    @(posedge clk); #1;                           // edge 5
    check("ignore_product_hold", product, last_exp);
    @(posedge clk); #1;                           // edge 6
    check("ignore_product", product, 10'd13);
    check("ignore_ready", {9'd0, ready}, 10'd1);
    last_exp = 10'd13;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || product !== last_exp)
        check("no_second_op", {ready, product[8:0]}, {1'b1, last_exp[8:0]});
    end
    check("no_second_op_state", {8'd0, dbg_state}, 10'd0);

    // Start held high: 2*3+4 = 10 at edge 6, new op at edge 7 with 6*7+1 = 43 at edge 13
    @(negedge clk);
    mc = 5'd2; ml = 5'd3; ad = 5'd4; start = 1'b1;
    @(posedge clk);                               // edge 0
    @(negedge clk); mc = 5'd6; ml = 5'd7; ad = 5'd1;
    repeat (6) @(posedge clk);
    #1;                                           // edge 6
    check("b2b_first", product, 10'd10);
    check("b2b_ready_hi", {9'd0, ready}, 10'd1);
    @(posedge clk); #1;                           // edge 7
    check("b2b_restart", {9'd0, ready}, 10'd0);
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);
    #1;                                           // edge 13
    check("b2b_second", product, 10'd43);
    last_exp = 10'd43;

    // Asynchronous reset mid-operation between edges 3 and 4
    @(negedge clk);
    mc = 5'd5; ml = 5'd5; ad = 5'd5; start = 1'b1;
    @(posedge clk);                               // edge 0
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);                    // edge 3
    #3 rst = 1'b0;
    #1;
    check("async_rst_ready", {9'd0, ready}, 10'd1);
    check("async_rst_product", product, 10'd0);
    last_exp = 10'd0;
    @(negedge clk); rst = 1'b1;
    run_op(5'd2, 5'd2, 5'd0, 10'd4, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before time limit");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
